// File: rtl/cpu16_pkg.sv
// -----------------------------------------------------------------------------
// cpu16_pkg
// Shared constants and types for the 16-bit CPU datapath blocks.
//   WORD_W      : datapath width in bits
//   SHAMT_W     : shift-amount width (max shift = 2**SHAMT_W - 1)
//   shl_state_t : control states of the iterative left shifter
// -----------------------------------------------------------------------------
package cpu16_pkg;

    localparam int WORD_W  = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shl_state_t;

endpackage

// File: rtl/shl_iter_unit_if.sv
// -----------------------------------------------------------------------------
// shl_iter_unit_if
// Request/response bundle of the iterative left shifter.
//   start, a, shamt (and rot when SHL_ROTATE_EN is defined) : requester -> unit
//   busy, done, result, carry, ovf                           : unit -> requester
// Modports: master = requester (ALU / testbench), slave = shl_iter_unit.
// Optional feature macro: SHL_ROTATE_EN (adds the rot request bit).
// -----------------------------------------------------------------------------
interface shl_iter_unit_if;
    import cpu16_pkg::*;

    logic               start;
    logic [WORD_W-1:0]  a;
    logic [SHAMT_W-1:0] shamt;
`ifdef SHL_ROTATE_EN
    logic               rot;
`endif
    logic               busy;
    logic               done;
    logic [WORD_W-1:0]  result;
    logic               carry;
    logic               ovf;

`ifdef SHL_ROTATE_EN
    modport master (output start, a, shamt, rot,
                    input  busy, done, result, carry, ovf);
    modport slave  (input  start, a, shamt, rot,
                    output busy, done, result, carry, ovf);
`else
    modport master (output start, a, shamt,
                    input  busy, done, result, carry, ovf);
    modport slave  (input  start, a, shamt,
                    output busy, done, result, carry, ovf);
`endif

endinterface

// File: rtl/shl_iter_unit.sv
// -----------------------------------------------------------------------------
// shl_iter_unit
// Multi-cycle logical left shifter: shifts one bit per clock under a
// start/done handshake and reports carry-out and a sticky signed-overflow flag.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (discards any operation in flight)
//   bus   : shl_iter_unit_if.slave (start/a/shamt[/rot] in,
//           busy/done/result/carry/ovf out)
// Optional feature macro: SHL_ROTATE_EN -- adds rot; when set, each step
// rotates instead of shifting and ovf is held at 0.
// -----------------------------------------------------------------------------
module shl_iter_unit
    import cpu16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    shl_iter_unit_if.slave bus
);

    shl_state_t         state_reg;
    logic [WORD_W-1:0]  result_reg;
    logic [SHAMT_W-1:0] count_reg;
    logic               carry_reg;
    logic               ovf_reg;

    // Bit entering position 0 and the per-step sign-change term.
    logic               fill_bit;
    logic               ovf_step;

`ifdef SHL_ROTATE_EN
    logic               rot_reg;

    assign fill_bit = rot_reg & result_reg[WORD_W-1];
    // Rotation is not an arithmetic operation, so it never flags overflow.
    assign ovf_step = ~rot_reg & (result_reg[WORD_W-1] ^ result_reg[WORD_W-2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_reg <= 1'b0;
        end else if (state_reg == IDLE && bus.start) begin
            rot_reg <= bus.rot;
        end
    end
`else
    assign fill_bit = 1'b0;
    // The sign changes on this step when the bit about to become the MSB
    // differs from the current MSB.
    assign ovf_step = result_reg[WORD_W-1] ^ result_reg[WORD_W-2];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            count_reg  <= '0;
            carry_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        result_reg <= bus.a;
                        count_reg  <= bus.shamt;
                        carry_reg  <= 1'b0;
                        ovf_reg    <= 1'b0;
                        // A zero shift still goes through DONE so the
                        // requester always sees exactly one done pulse.
                        state_reg  <= (bus.shamt != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    result_reg <= {result_reg[WORD_W-2:0], fill_bit};
                    carry_reg  <= result_reg[WORD_W-1];
                    ovf_reg    <= ovf_reg | ovf_step;
                    count_reg  <= count_reg - SHAMT_W'(1);
                    if (count_reg == SHAMT_W'(1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (state_reg != IDLE);
    assign bus.done   = (state_reg == DONE);
    assign bus.result = result_reg;
    assign bus.carry  = carry_reg;
    assign bus.ovf    = ovf_reg;

endmodule
